// File: rtl/feram_pkg.sv
// Shared types for the FeRAM row streamer: row geometry, read-side FSM states
// and the row-buffer entry shared with the write-side packer.
package feram_pkg;

  localparam int FERAM_ADDR_W = 4;
  localparam int FERAM_DATA_W = 8;
  localparam int FERAM_LANES  = 4;
  localparam int FERAM_N_ROWS = 16;
  localparam int ROW_W        = FERAM_LANES * FERAM_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [ROW_W-1:0]        data;
    logic [FERAM_ADDR_W-1:0] row;
    logic                    last;
  } row_entry_t;

endpackage

// File: rtl/feram_row_fifo2.sv
// Two-entry synchronous FIFO of row entries; simultaneous push and pop are
// both honoured. The caller guarantees it never pushes when full or pops when empty.
module feram_row_fifo2
  import feram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  row_entry_t push_entry_i,
  input  logic       pop_i,
  output row_entry_t head_o,
  output logic [1:0] count_o
);

  row_entry_t mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // NOTE: the storage has no reset; occupancy alone decides whether the head is meaningful.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/feram_row_streamer.sv
// FeRAM read initiator: issues one row read per cycle and streams rows out
// through a 2-entry buffer. FERAM_STREAM_WRAP_EN enables row-address wrap-around.
module feram_row_streamer
  import feram_pkg::*;
#(
  parameter int ADDR_W = FERAM_ADDR_W,
  parameter int DATA_W = FERAM_DATA_W,
  parameter int LANES  = FERAM_LANES,
  parameter int N_ROWS = FERAM_N_ROWS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_W-1:0]       cmd_base,
  input  logic [ADDR_W:0]         cmd_count,
  input  logic                    mem_hold,
  output logic                    sra_en,
  output logic [ADDR_W-1:0]       row_addr,
  input  logic [LANES*DATA_W-1:0] rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]       out_row,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    cmd_err
);

  localparam logic [ADDR_W+1:0] N_ROWS_C = N_ROWS[ADDR_W+1:0];
  localparam logic [ADDR_W:0]   ONE_C    = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic              done_q, done_d;
  logic              cmd_err_q, cmd_err_d;
  logic              pend_q, pend_last_q;
  logic [ADDR_W-1:0] pend_row_q, row_addr_q;

  logic              cmd_ok, pop;
  logic [1:0]        fifo_count, occ_next;
  logic [ADDR_W+1:0] addr_sum;
  logic [ADDR_W-1:0] issue_addr;
  row_entry_t        push_entry, head;

`ifdef FERAM_STREAM_WRAP_EN
  assign cmd_ok = (cmd_count != '0) && ({1'b0, cmd_count} <= N_ROWS_C);
`else
  assign cmd_ok = (cmd_count != '0) && ({2'b00, cmd_base} + {1'b0, cmd_count} <= N_ROWS_C);
`endif

  // Without wrap the sum never reaches N_ROWS, so the fold is inert there.
  assign addr_sum   = {2'b00, base_q} + {1'b0, issued_q};
  assign issue_addr = (addr_sum >= N_ROWS_C) ? ADDR_W'(addr_sum - N_ROWS_C)
                                             : addr_sum[ADDR_W-1:0];

  // Throttle on occupancy after this cycle's pop so a full-rate stream never stalls.
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign occ_next  = fifo_count - {1'b0, pop} + {1'b0, pend_q};
  assign sra_en    = (state_q == ST_ISSUE) && !mem_hold && (issued_q != count_q)
                     && (occ_next < 2'd2);
  assign row_addr  = sra_en ? issue_addr : row_addr_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    issued_d  = issued_q;
    done_d    = 1'b0;
    cmd_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_ok) begin
            base_d   = cmd_base;
            count_d  = cmd_count;
            issued_d = '0;
            state_d  = ST_ISSUE;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (sra_en) begin
          issued_d = issued_q + ONE_C;
          if (issued_d == count_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pend_q && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop))) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_row_q  <= '0;
      row_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      cmd_err_q   <= cmd_err_d;
      pend_q      <= sra_en;
      pend_last_q <= sra_en && ((issued_q + ONE_C) == count_q);
      row_addr_q  <= row_addr;
      if (sra_en) pend_row_q <= issue_addr;
    end
  end

  assign push_entry = '{data: rd_data, row: pend_row_q, last: pend_last_q};

  feram_row_fifo2 u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (pend_q),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  assign out_data  = out_valid ? head.data : '0;
  assign out_row   = out_valid ? head.row  : '0;
  assign out_last  = out_valid && head.last;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_feram_row_streamer.sv
// Directed bench for feram_row_streamer with a one-cycle-latency row memory model.
`timescale 1ns/1ps
module tb_feram_row_streamer;

  localparam int AW = 4;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;
  logic          mem_hold, sra_en;
  logic [AW-1:0] row_addr, out_row;
  logic [RW-1:0] rd_data, out_data;
  logic          out_valid, out_ready, out_last, busy, done, cmd_err;

  logic [RW-1:0] mem [16];
  logic [RW-1:0] rd_q;

  int checks = 0;
  int errors = 0;

  feram_row_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_count (cmd_count),
    .mem_hold  (mem_hold),
    .sra_en    (sra_en),
    .row_addr  (row_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sra_en) rd_q <= mem[row_addr];
  assign rd_data = rd_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_stream(input int base, input int cnt, input logic [3:0] rpat,
                            input int hold_from, input int hold_len, input bit chk_lat);
    int  issued = 0;
    int  beats = 0;
    int  last_k = -1;
    bit  done_seen = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_base  = AW'(base);
    cmd_count = (AW+1)'(cnt);
    out_ready = 1'b0;
    mem_hold  = 1'b0;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      out_ready = rpat[(k-1)%4];
      mem_hold  = (k >= hold_from) && (k < hold_from + hold_len);
      #1;
      if (mem_hold) check("sra_during_hold", sra_en, 0);
      if (chk_lat && k == 1) check("first_sra", sra_en, 1);
      if (chk_lat && k <= 2) check("early_valid", out_valid, 0);
      if (chk_lat && k == 3) check("first_valid", out_valid, 1);
      if (sra_en) begin
        check("row_addr", row_addr, (base + issued) % 16);
        issued++;
      end
      if (out_valid && out_ready) begin
        check("out_data", out_data, mem[(base + beats) % 16]);
        check("out_row", out_row, (base + beats) % 16);
        check("out_last", out_last, beats == cnt - 1);
        beats++;
        if (beats == cnt) begin
          last_k = k;
          if (chk_lat && rpat == 4'b1111) check("full_rate_last_cycle", k, 2 + cnt);
        end
      end
      check("outstanding_le_2", (issued - beats) <= 2, 1);
      if (last_k > 0 && k == last_k + 1) begin
        check("done_pulse", done, 1);
        check("cmd_ready_with_done", cmd_ready, 1);
        check("busy_with_done", busy, 0);
        done_seen = 1;
        break;
      end else begin
        check("no_early_done", done, 0);
      end
    end
    check("beat_count", beats, cnt);
    check("done_seen", done_seen, 1);
    out_ready = 1'b0;
    mem_hold  = 1'b0;
    @(negedge clk);
    #1 check("done_one_cycle", done, 0);
  endtask

  task automatic run_reject(input int base, input int cnt);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_base  = AW'(base);
    cmd_count = (AW+1)'(cnt);
    #1 check("rej_cmd_ready", cmd_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      check("rej_cmd_err", cmd_err, k == 1);
      check("rej_busy", busy, 0);
      check("rej_sra", sra_en, 0);
      check("rej_valid", out_valid, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hF00D_0000 + i;
    mem[0] = 32'hDDCCBBAA;
    mem[1] = 32'h11223344;
    mem[2] = 32'h55667788;
    mem[3] = 32'h99AABBCC;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_count = '0;
    mem_hold  = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sra", sra_en, 0);
    check("rst_done", done, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_row_addr", row_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-rate burst, then the same burst under output backpressure.
    run_stream(0, 4, 4'b1111, 0, 0, 1);
    run_stream(0, 4, 4'b1001, 0, 0, 0);

    // Writer holds the interface for three cycles after the first read.
    run_stream(2, 3, 4'b1111, 2, 3, 0);

`ifdef FERAM_STREAM_WRAP_EN
    run_stream(14, 4, 4'b1111, 0, 0, 1);
`else
    run_reject(14, 4);
`endif

    run_reject(0, 0);

    // Asynchronous reset in the middle of a burst with rows buffered.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_base  = '0;
    cmd_count = 5'd4;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    #1 check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_sra", sra_en, 0);
    check("mid_rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_valid", out_valid, 0);
      check("post_rst_sra", sra_en, 0);
    end
    run_stream(0, 1, 4'b1111, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
